// File: rtl/ring_scheduler.sv
// ring_scheduler: arbitrates the single speaker path between the alarm ring
// and the hourly chime, with snooze and auto-timeout handling. All durations
// are in seconds, counted on the one-cycle sec_tick from the timekeeping chain.
module ring_scheduler #(
    parameter int RING_SECS   = 60,   // alarm ring duration before timeout (1..255)
    parameter int SNOOZE_SECS = 240,  // snooze duration before re-ringing (1..1023)
    parameter int CHIME_SECS  = 5,    // chime burst duration (1..15)
    parameter int MAX_SNOOZE  = 3     // snoozes allowed per alarm event (0..7)
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       EN_work,
    input  logic       sec_tick,
    input  logic       alarm_match,
    input  logic       chime_req,
    input  logic       Off,
    input  logic       Snooze,
    output logic       ring,
    output logic       chime,
    output logic       snoozing,
    output logic [2:0] snooze_cnt
);

    // The down-counter must hold the longest of the three durations.
    localparam int MAX_RS   = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int MAX_SECS = (MAX_RS > CHIME_SECS) ? MAX_RS : CHIME_SECS;
    localparam int CNT_W    = $clog2(MAX_SECS + 1);

    localparam logic [CNT_W-1:0] RING_LD   = CNT_W'(RING_SECS);
    localparam logic [CNT_W-1:0] SNOOZE_LD = CNT_W'(SNOOZE_SECS);
    localparam logic [CNT_W-1:0] CHIME_LD  = CNT_W'(CHIME_SECS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       SNZ_MAX   = 3'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHIME  = 2'd1,
        S_ALARM  = 2'd2,
        S_SNOOZE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       snz_q, snz_d;
    logic             match_q;

    logic             alarm_edge;
    logic             timeout;
    logic             can_snooze;
    logic             load;
    logic [CNT_W-1:0] load_val;

    // Saturating increment of the per-event snooze count; callers only use it
    // below MAX_SNOOZE, the clamp keeps the count bounded regardless.
    function automatic logic [2:0] snooze_inc(input logic [2:0] cnt);
        if (cnt >= SNZ_MAX) begin
            return SNZ_MAX;
        end
        return cnt + 3'd1;
    endfunction

    // One trigger per matching minute: only the rising edge of alarm_match counts.
    assign alarm_edge = alarm_match & ~match_q;
    // Timeout is the tick that would take the counter from 1 to 0.
    assign timeout    = sec_tick && (cnt_q == CNT_ONE);
    // Snooze count never exceeds SNZ_MAX, so inequality means room is left.
    assign can_snooze = (MAX_SNOOZE != 0) && (snz_q != SNZ_MAX);

    // State, counter, snooze count and alarm-match history registers.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            snz_q   <= 3'd0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snz_q   <= snz_d;
            match_q <= alarm_match;
        end
    end

    // Next-state logic; priority is EN_work > Off > Snooze > timeout > alarm_edge > chime_req.
    always_comb begin
        state_d  = state_q;
        snz_d    = snz_q;
        load     = 1'b0;
        load_val = '0;

        if (!EN_work) begin
            state_d  = S_IDLE;
            snz_d    = 3'd0;
            load     = 1'b1;
            load_val = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Alarm wins over a simultaneous chime request; the chime is dropped.
                    if (alarm_edge) begin
                        state_d  = S_ALARM;
                        snz_d    = 3'd0;
                        load     = 1'b1;
                        load_val = RING_LD;
                    end else if (chime_req) begin
                        state_d  = S_CHIME;
                        load     = 1'b1;
                        load_val = CHIME_LD;
                    end
                end

                S_CHIME: begin
                    // A new alarm preempts the chime; the chime is not resumed later.
                    if (Off || timeout) begin
                        state_d  = S_IDLE;
                        load     = 1'b1;
                        load_val = '0;
                    end else if (alarm_edge) begin
                        state_d  = S_ALARM;
                        snz_d    = 3'd0;
                        load     = 1'b1;
                        load_val = RING_LD;
                    end
                end

                S_ALARM: begin
                    if (Off) begin
                        state_d  = S_IDLE;
                        snz_d    = 3'd0;
                        load     = 1'b1;
                        load_val = '0;
                    end else if (Snooze && can_snooze) begin
                        state_d  = S_SNOOZE;
                        snz_d    = snooze_inc(snz_q);
                        load     = 1'b1;
                        load_val = SNOOZE_LD;
                    end else if (timeout) begin
                        // An unanswered ring behaves like a snooze until snoozes run out.
                        if (can_snooze) begin
                            state_d  = S_SNOOZE;
                            snz_d    = snooze_inc(snz_q);
                            load     = 1'b1;
                            load_val = SNOOZE_LD;
                        end else begin
                            state_d  = S_IDLE;
                            snz_d    = 3'd0;
                            load     = 1'b1;
                            load_val = '0;
                        end
                    end
                end

                S_SNOOZE: begin
                    if (Off) begin
                        state_d  = S_IDLE;
                        snz_d    = 3'd0;
                        load     = 1'b1;
                        load_val = '0;
                    end else if (timeout) begin
                        state_d  = S_ALARM;
                        load     = 1'b1;
                        load_val = RING_LD;
                    end
                end

                default: begin
                    state_d  = S_IDLE;
                    snz_d    = 3'd0;
                    load     = 1'b1;
                    load_val = '0;
                end
            endcase
        end
    end

    // Counter next value: a state entry loads the full duration and swallows any
    // coincident tick; otherwise count down once per second until zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (sec_tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Moore outputs decoded from the state register, so they clear with reset.
    always_comb begin
        ring       = (state_q == S_ALARM);
        chime      = (state_q == S_CHIME);
        snoozing   = (state_q == S_SNOOZE);
        snooze_cnt = snz_q;
    end

endmodule

// File: tb/tb_ring_scheduler.sv
// Testbench for ring_scheduler: table-driven per-cycle vectors on a
// MAX_SNOOZE=2 instance, plus hand sequences for MAX_SNOOZE=0 timeout and
// asynchronous reset during a chime.
module tb_ring_scheduler;

    logic       CLK = 1'b0;
    logic       RST_n;
    logic       EN_work, sec_tick, alarm_match, chime_req, Off, Snooze;
    logic       ring, chime, snoozing;
    logic [2:0] snooze_cnt;

    logic       en0, alarm0, chime0_req, off0, snz0;
    logic       ring0, chime0, snoozing0;
    logic [2:0] snooze_cnt0;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [5:0] in;   // {EN_work, sec_tick, alarm_match, chime_req, Off, Snooze}
        logic [2:0] out;  // {ring, chime, snoozing}
        logic [2:0] n;    // snooze_cnt
    } vec_t;

    vec_t tbl[$];

    always #5 CLK = ~CLK;

    ring_scheduler #(
        .RING_SECS(3), .SNOOZE_SECS(4), .CHIME_SECS(5), .MAX_SNOOZE(2)
    ) dut (
        .CLK(CLK), .RST_n(RST_n), .EN_work(EN_work), .sec_tick(sec_tick),
        .alarm_match(alarm_match), .chime_req(chime_req), .Off(Off), .Snooze(Snooze),
        .ring(ring), .chime(chime), .snoozing(snoozing), .snooze_cnt(snooze_cnt)
    );

    ring_scheduler #(
        .RING_SECS(3), .SNOOZE_SECS(4), .CHIME_SECS(5), .MAX_SNOOZE(0)
    ) dut0 (
        .CLK(CLK), .RST_n(RST_n), .EN_work(en0), .sec_tick(sec_tick),
        .alarm_match(alarm0), .chime_req(chime0_req), .Off(off0), .Snooze(snz0),
        .ring(ring0), .chime(chime0), .snoozing(snoozing0), .snooze_cnt(snooze_cnt0)
    );

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {ring,chime,snoozing,cnt}=%b, expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] in, input logic [2:0] out, input logic [2:0] n);
        vec_t v;
        v.in  = in;
        v.out = out;
        v.n   = n;
        tbl.push_back(v);
    endtask

    task automatic apply(input logic [5:0] in);
        @(negedge CLK);
        {EN_work, sec_tick, alarm_match, chime_req, Off, Snooze} = in;
        @(posedge CLK);
        #1;
    endtask

    task automatic apply0(input logic a, input logic s, input logic t);
        @(negedge CLK);
        alarm0   = a;
        snz0     = s;
        sec_tick = t;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_n = 1'b0;
        {EN_work, sec_tick, alarm_match, chime_req, Off, Snooze} = 6'b100000;
        en0 = 1'b1; alarm0 = 1'b0; chime0_req = 1'b0; off0 = 1'b0; snz0 = 1'b0;

        #12;
        chk("reset_main", {ring, chime, snoozing, snooze_cnt}, 6'b000000);
        chk("reset_max0", {ring0, chime0, snoozing0, snooze_cnt0}, 6'b000000);
        @(negedge CLK);
        RST_n = 1'b1;

        // Alarm dismiss, no retrigger while alarm_match stays high
        add(6'b101000, 3'b100, 3'd0);
        add(6'b111000, 3'b100, 3'd0);
        add(6'b101010, 3'b000, 3'd0);
        add(6'b101000, 3'b000, 3'd0);
        add(6'b111000, 3'b000, 3'd0);
        add(6'b100000, 3'b000, 3'd0);
        // Chime preempted by an alarm edge, no chime resumes after Off
        add(6'b100100, 3'b010, 3'd0);
        add(6'b110000, 3'b010, 3'd0);
        add(6'b110000, 3'b010, 3'd0);
        add(6'b101000, 3'b100, 3'd0);
        add(6'b101010, 3'b000, 3'd0);
        add(6'b100000, 3'b000, 3'd0);
        add(6'b110000, 3'b000, 3'd0);
        // Chime entry swallows a coincident tick, lasts 5 ticks, ignores chime_req
        add(6'b110100, 3'b010, 3'd0);
        add(6'b110000, 3'b010, 3'd0);
        add(6'b110000, 3'b010, 3'd0);
        add(6'b110100, 3'b010, 3'd0);
        add(6'b110000, 3'b010, 3'd0);
        add(6'b110000, 3'b000, 3'd0);
        // Alarm and chime together -> alarm; Off and Snooze together -> IDLE
        add(6'b101100, 3'b100, 3'd0);
        add(6'b100011, 3'b000, 3'd0);
        add(6'b100000, 3'b000, 3'd0);
        // Snooze twice (4 ticks each), third Snooze ignored, final timeout -> IDLE
        add(6'b101000, 3'b100, 3'd0);
        add(6'b100001, 3'b001, 3'd1);
        add(6'b110000, 3'b001, 3'd1);
        add(6'b110000, 3'b001, 3'd1);
        add(6'b111100, 3'b001, 3'd1);
        add(6'b110000, 3'b100, 3'd1);
        add(6'b100001, 3'b001, 3'd2);
        add(6'b110000, 3'b001, 3'd2);
        add(6'b110000, 3'b001, 3'd2);
        add(6'b110000, 3'b001, 3'd2);
        add(6'b110000, 3'b100, 3'd2);
        add(6'b100001, 3'b100, 3'd2);
        add(6'b110000, 3'b100, 3'd2);
        add(6'b110000, 3'b100, 3'd2);
        add(6'b110000, 3'b000, 3'd0);
        // Unanswered ring times out into SNOOZE; Off from SNOOZE clears count
        add(6'b101000, 3'b100, 3'd0);
        add(6'b110000, 3'b100, 3'd0);
        add(6'b110000, 3'b100, 3'd0);
        add(6'b110000, 3'b001, 3'd1);
        add(6'b100010, 3'b000, 3'd0);
        // EN_work drop during SNOOZE; match history still tracked while disabled
        add(6'b101000, 3'b100, 3'd0);
        add(6'b100001, 3'b001, 3'd1);
        add(6'b000000, 3'b000, 3'd0);
        add(6'b001100, 3'b000, 3'd0);
        add(6'b101000, 3'b000, 3'd0);
        add(6'b100000, 3'b000, 3'd0);

        foreach (tbl[i]) begin
            apply(tbl[i].in);
            chk($sformatf("row%0d", i + 1), {ring, chime, snoozing, snooze_cnt},
                {tbl[i].out, tbl[i].n});
        end

        // MAX_SNOOZE=0: Snooze has no effect, ring lasts exactly 3 ticks then IDLE
        apply(6'b100000);
        apply0(1'b1, 1'b0, 1'b0);
        chk("max0_ring", {ring0, chime0, snoozing0, snooze_cnt0}, 6'b100000);
        apply0(1'b0, 1'b1, 1'b0);
        chk("max0_snooze_ignored", {ring0, chime0, snoozing0, snooze_cnt0}, 6'b100000);
        apply0(1'b0, 1'b0, 1'b1);
        chk("max0_tick1", {ring0, chime0, snoozing0, snooze_cnt0}, 6'b100000);
        apply0(1'b0, 1'b0, 1'b1);
        chk("max0_tick2", {ring0, chime0, snoozing0, snooze_cnt0}, 6'b100000);
        apply0(1'b0, 1'b0, 1'b1);
        chk("max0_timeout", {ring0, chime0, snoozing0, snooze_cnt0}, 6'b000000);
        chk("max0_main_idle", {ring, chime, snoozing, snooze_cnt}, 6'b000000);
        apply0(1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-chime silences chime before the next edge
        apply(6'b100100);
        chk("chime_on", {ring, chime, snoozing, snooze_cnt}, 6'b010000);
        apply(6'b100000);
        chk("chime_hold", {ring, chime, snoozing, snooze_cnt}, 6'b010000);
        #2;
        RST_n = 1'b0;
        #1;
        chk("async_reset_chime", {ring, chime, snoozing, snooze_cnt}, 6'b000000);
        @(negedge CLK);
        RST_n = 1'b1;
        apply(6'b110000);
        chk("after_reset_idle", {ring, chime, snoozing, snooze_cnt}, 6'b000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_scheduler.md
Name: ring_scheduler

Overview:
- Sequences and arbitrates the single speaker path between the alarm ring and the hourly chime, and adds snooze and timeout handling.
- Sits between the alarm comparator and chime pulse generator on one side and the music output block on the other.
- Drives the ring and chime enables that the music block currently takes directly.
- All timing is counted in seconds, using a one-cycle second tick from the timekeeping chain.

Parameters:
RING_SECS, 60, seconds an alarm rings before auto-timeout (1..255)
SNOOZE_SECS, 240, seconds spent in snooze before re-ringing (1..1023)
CHIME_SECS, 5, seconds a chime burst lasts (1..15)
MAX_SNOOZE, 3, snoozes allowed per alarm event before snooze is ignored (0..7)

Ports:
CLK  input  1  system clock, rising edge
RST_n  input  1  asynchronous active-low reset
EN_work  input  1  1 = clock running; 0 = forces IDLE and silences outputs
sec_tick  input  1  one-CLK pulse per elapsed second
alarm_match  input  1  level, high while the current time equals the alarm setting
chime_req  input  1  one-CLK pulse requesting an hourly chime
Off  input  1  one-CLK pulse, dismiss the alarm or snooze
Snooze  input  1  one-CLK pulse, snooze a ringing alarm
ring  output  1  alarm tone enable to the music block
chime  output  1  chime tone enable to the music block
snoozing  output  1  high in SNOOZE, drives the display indicator
snooze_cnt  output  3  snoozes used in the current alarm event

Behaviour:
- Reset (RST_n=0, asynchronous): state=IDLE, sec counter=0, snooze_cnt=0, match_d=0; ring, chime and snoozing are 0.
- Alarm detection: match_d registers alarm_match. alarm_edge = alarm_match & ~match_d, so one trigger fires per matching minute. match_d updates in every state.
- States: IDLE, CHIME, ALARM, SNOOZE. Outputs are registered Moore outputs: ring=(state==ALARM), chime=(state==CHIME), snoozing=(state==SNOOZE). An output changes one cycle after the triggering input.
- Down-counter: width covers max(RING_SECS, SNOOZE_SECS, CHIME_SECS).
  - Loaded on every state entry with that state's duration.
  - Decremented only on sec_tick.
  - A timeout occurs when sec_tick arrives with the counter equal to 1.
- IDLE:
  - alarm_edge -> ALARM; load RING_SECS; snooze_cnt=0.
  - Otherwise chime_req -> CHIME; load CHIME_SECS.
  - If both arrive in the same cycle, the alarm wins and the chime is dropped.
- CHIME:
  - Timeout -> IDLE.
  - alarm_edge -> ALARM immediately (preempts the chime); load RING_SECS; snooze_cnt=0.
  - chime_req is ignored.
  - Off -> IDLE.
- ALARM:
  - Off -> IDLE; snooze_cnt=0.
  - Else Snooze with snooze_cnt<MAX_SNOOZE -> SNOOZE; snooze_cnt+1; load SNOOZE_SECS.
  - Snooze with snooze_cnt==MAX_SNOOZE is ignored.
  - Else timeout -> treated exactly as Snooze if snooze_cnt<MAX_SNOOZE, otherwise -> IDLE with snooze_cnt=0.
  - chime_req and alarm_edge are ignored.
- SNOOZE:
  - Off -> IDLE; snooze_cnt=0.
  - Timeout -> ALARM; load RING_SECS; snooze_cnt held.
  - Snooze, chime_req and alarm_edge are ignored.
- Priority within one cycle: EN_work=0 > Off > Snooze > timeout > alarm_edge > chime_req.
- EN_work=0 (synchronous):
  - Forces state=IDLE, counter=0 and snooze_cnt=0 on the next CLK.
  - While EN_work is low, all requests are ignored; match_d still tracks alarm_match.
- sec_tick in the same cycle as a state entry: the counter loads the full duration and the tick is not applied.
- snooze_cnt saturates at MAX_SNOOZE. With MAX_SNOOZE=0, Snooze never has effect and a timeout goes straight to IDLE.
- A reset assertion mid-ring silences ring and chime asynchronously.

Test Plan:
- Alarm dismiss: pulse alarm_match high for 60 ticks, pulse Off at tick 10 -> ring rises one cycle after the edge, falls one cycle after Off; no re-trigger while alarm_match stays high.
- Chime preemption: chime_req, then alarm edge 2 ticks later -> chime falls and ring rises in the same cycle; after Off, no chime resumes.
- Snooze cycle (SNOOZE_SECS=4, MAX_SNOOZE=2):
  - Snooze, Snooze, then a third Snooze -> snoozing high for exactly 4 ticks each time, then ring returns; snooze_cnt reads 1 then 2.
  - The third Snooze is ignored and ring stays high.
- Timeout (RING_SECS=3, MAX_SNOOZE=0): ring with no buttons -> ring is high for exactly 3 ticks, then IDLE with snooze_cnt=0.
- Simultaneous events:
  - Off and Snooze in the same cycle -> IDLE.
  - alarm_edge and chime_req in the same cycle from IDLE -> ALARM, chime stays 0.
- Disable and reset:
  - Drop EN_work during SNOOZE -> IDLE next cycle, all outputs 0.
  - Assert RST_n low mid-CHIME -> chime goes 0 without waiting for a CLK edge.
